// File: rtl/udp_dff_reg.sv
// WIDTH-bit edge-triggered D register with enable, write mask and change tracking.
// Optional `UDP_DFF_XHOLD_EN: X/Z data bits hold q and raise x_seen (simulation only).
module udp_dff_reg #(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter int               CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] wmask,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             q_changed,
`ifdef UDP_DFF_XHOLD_EN
    output logic             x_seen,
`endif
    output logic [CNT_W-1:0] chg_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] wr;
    logic             chg_q, chg_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

`ifdef UDP_DFF_XHOLD_EN
    logic [WIDTH-1:0] dx;
    logic             xs_q, xs_d;

    always_comb begin
        dx = '0;
        for (int i = 0; i < WIDTH; i++) begin
            dx[i] = $isunknown(d[i]);
        end
    end

    assign wr   = en ? (wmask & ~dx) : '0;
    assign xs_d = en & (|(wmask & dx));
`else
    assign wr = en ? wmask : '0;
`endif

    assign q_d   = (q_q & ~wr) | (d & wr);
    assign chg_d = (q_d != q_q);

    always_comb begin
        cnt_d = cnt_q;
        if (chg_d && cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Reset wins over en and drops the capture pending in the same cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q_q   <= RESET_VAL;
            chg_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            q_q   <= q_d;
            chg_q <= chg_d;
            cnt_q <= cnt_d;
        end
    end

`ifdef UDP_DFF_XHOLD_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            xs_q <= 1'b0;
        end else begin
            xs_q <= xs_d;
        end
    end

    assign x_seen = xs_q;
`endif

    assign q         = q_q;
    assign q_changed = chg_q;
    assign chg_cnt   = cnt_q;

endmodule

// File: tb/tb_udp_dff_reg.sv
// Table-driven scoreboard bench for udp_dff_reg (WIDTH=8, CNT_W=2).
module tb_udp_dff_reg;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [7:0] wmask;
    logic [7:0] d;
    logic [7:0] q;
    logic       q_changed;
    logic [1:0] chg_cnt;
`ifdef UDP_DFF_XHOLD_EN
    logic       x_seen;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       rst_n;
        logic       en;
        logic [7:0] wm;
        logic [7:0] d;
        logic [7:0] eq;
        logic       ec;
        logic [1:0] ecnt;
    } vec_t;

    typedef struct {
        logic [7:0] q;
        logic       c;
        logic [1:0] n;
        string      name;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];

    udp_dff_reg #(
        .WIDTH    (8),
        .RESET_VAL(8'h00),
        .CNT_W    (2)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .wmask    (wmask),
        .d        (d),
        .q        (q),
        .q_changed(q_changed),
`ifdef UDP_DFF_XHOLD_EN
        .x_seen   (x_seen),
`endif
        .chg_cnt  (chg_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: act=timeout req=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic push(input logic [7:0] eq, input logic ec,
                        input logic [1:0] en_, input string nm);
        exp_t e;
        e.q = eq; e.c = ec; e.n = en_; e.name = nm;
        sb.push_back(e);
    endtask

    task automatic pop_check();
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard: act=empty req=entry");
            return;
        end
        e = sb.pop_front();
        checks++;
        if (q !== e.q || q_changed !== e.c || chg_cnt !== e.n) begin
            errors++;
            $display("FAIL %s: act q=%h chg=%b cnt=%0d req q=%h chg=%b cnt=%0d",
                     e.name, q, q_changed, chg_cnt, e.q, e.c, e.n);
        end
    endtask

    task automatic drive(input logic r, input logic e, input logic [7:0] w,
                         input logic [7:0] dd);
        rst_n = r; en = e; wmask = w; d = dd;
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; wmask = '0; d = '0;

        // reset (2 edges), basic capture, reset
        vecs.push_back('{0, 0, 8'h00, 8'h00, 8'h00, 0, 2'd0});
        vecs.push_back('{0, 0, 8'h00, 8'h00, 8'h00, 0, 2'd0});
        vecs.push_back('{1, 1, 8'hFF, 8'h01, 8'h01, 1, 2'd1});
        vecs.push_back('{1, 1, 8'hFF, 8'h01, 8'h01, 0, 2'd1});
        vecs.push_back('{1, 1, 8'hFF, 8'h00, 8'h00, 1, 2'd2});
        vecs.push_back('{0, 1, 8'hFF, 8'hAA, 8'h00, 0, 2'd0});
        // enable / mask
        vecs.push_back('{1, 0, 8'hFF, 8'hFF, 8'h00, 0, 2'd0});
        vecs.push_back('{1, 1, 8'h0F, 8'hFF, 8'h0F, 1, 2'd1});
        vecs.push_back('{1, 0, 8'hFF, 8'hFF, 8'h0F, 0, 2'd1});
        vecs.push_back('{1, 1, 8'h00, 8'h00, 8'h0F, 0, 2'd1});
        vecs.push_back('{1, 1, 8'hFF, 8'h0F, 8'h0F, 0, 2'd1});
        // saturation: toggle 6 edges
        vecs.push_back('{1, 1, 8'hFF, 8'h00, 8'h00, 1, 2'd2});
        vecs.push_back('{1, 1, 8'hFF, 8'hFF, 8'hFF, 1, 2'd3});
        vecs.push_back('{1, 1, 8'hFF, 8'h00, 8'h00, 1, 2'd3});
        vecs.push_back('{1, 1, 8'hFF, 8'hFF, 8'hFF, 1, 2'd3});
        vecs.push_back('{1, 1, 8'hFF, 8'h00, 8'h00, 1, 2'd3});
        vecs.push_back('{1, 1, 8'hFF, 8'hFF, 8'hFF, 1, 2'd3});
        // mid-operation reset drops capture; no pulse after
        vecs.push_back('{0, 1, 8'hFF, 8'h01, 8'h00, 0, 2'd0});
        vecs.push_back('{1, 0, 8'hFF, 8'h01, 8'h00, 0, 2'd0});
        // partial masks
        vecs.push_back('{1, 1, 8'hA5, 8'h3C, 8'h24, 1, 2'd1});
        vecs.push_back('{1, 1, 8'h5A, 8'hC3, 8'h66, 1, 2'd2});

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i].rst_n, vecs[i].en, vecs[i].wm, vecs[i].d);
            push(vecs[i].eq, vecs[i].ec, vecs[i].ecnt, $sformatf("vec%0d", i));
            @(posedge clk);
            #1 pop_check();
        end

        // timing sequence: capture 1, hold over falling and next rising edge
        @(negedge clk);
        drive(1'b0, 1'b1, 8'hFF, 8'h00);
        push(8'h00, 1'b0, 2'd0, "seq_rst");
        @(posedge clk);
        #1 pop_check();
        @(negedge clk);
        #3 drive(1'b1, 1'b1, 8'hFF, 8'h01);
        push(8'h01, 1'b1, 2'd1, "seq_rise1");
        @(posedge clk);
        #1 pop_check();
        @(negedge clk);
        #1 push(8'h01, 1'b1, 2'd1, "seq_fall_hold");
        pop_check();
        @(posedge clk);
        #1 push(8'h01, 1'b0, 2'd1, "seq_rise_hold");
        pop_check();
        #7 drive(1'b1, 1'b1, 8'hFF, 8'h00);
        push(8'h00, 1'b1, 2'd2, "seq_rise0");
        @(posedge clk);
        #1 pop_check();

        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_drain: act=%0d req=0", sb.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/udp_dff_reg.md
Name: udp_dff_reg

Overview:
- Edge-triggered D storage register modelled on a sequential UDP-style D flip-flop, generalised to WIDTH bits.
- Captures `d` on the rising edge of `clk` and holds on every other edge.
- Adds a clock enable, a per-bit write mask and a change-detect pulse.
- Sits at module boundaries as a general-purpose sampling flop bank for control and status bits.

Parameters:
- WIDTH, 1, number of stored bits (1..64).
- RESET_VAL, 0, WIDTH-bit value loaded into `q` on reset.
- CNT_W, 8, width of the saturating capture-change counter.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- en  in  1  clock enable; capture occurs only when 1.
- wmask  in  WIDTH  per-bit write mask; 1 = bit may be updated.
- d  in  WIDTH  data to capture.
- q  out  WIDTH  registered output.
- q_changed  out  1  one-cycle pulse: `q` changed on the previous capture.
- chg_cnt  out  CNT_W  saturating count of captures that changed `q`.

Behaviour:
- All state is registered on the `clk` rising edge; there is no combinational path from `d` to `q`.
- Falling edges of `clk` never alter state (hold), matching the UDP "(?0) : -" rows.
- Reset:
  - Reset condition: `rst_n` = 0 sampled at a rising edge.
  - Values: `q` = RESET_VAL, `q_changed` = 0, `chg_cnt` = 0.
  - Reset has priority over `en`.
  - Reset asserted mid-operation discards the pending capture in that cycle.
- Capture, when `rst_n` = 1 and `en` = 1, per bit i:
  - q_next[i] = wmask[i] ? d[i] : q[i].
  - `wmask` = all-ones gives plain DFF behaviour: rising edge with d=0 gives q=0; d=1 gives q=1.
- When `en` = 0, `q` holds regardless of `d` and `wmask`.
- Latency: `d` sampled at edge N appears on `q` immediately after edge N (1-cycle register latency).
- q_changed:
  - Registered; equals 1 in the cycle after an edge where q_next != q, otherwise 0.
  - Cleared by reset.
  - Never asserted by reset itself, even if RESET_VAL differs from the prior `q`.
- chg_cnt:
  - Increments by 1 on each edge where q_next != q.
  - Saturates at 2^CNT_W-1 with no wrap.
  - Cleared only by reset.
- Simultaneous conditions:
  - `en` = 1 with `wmask` = 0 leaves `q` unchanged; no change pulse, no count.
  - `d` equal to `q` gives no change pulse.
- X/Z handling in RTL: none; `d` is treated as 2-state for synthesis. Clock X-transitions are outside the synthesizable scope.
- Power-up before the first reset: `q` is undefined; the bench must apply reset first.

Optional Feature:
- Macro: UDP_DFF_XHOLD_EN.
- When defined (simulation builds only): at a capture edge, any bit of `d` that is X or Z is not written; that `q` bit holds its previous value. This mirrors the UDP hold on undefined transitions.
- When defined, an extra output `x_seen` (1 bit) is present:
  - Registered.
  - Set to 1 for one cycle after any capture edge where an enabled, unmasked `d` bit was X/Z.
  - Reset value 0.
- When not defined: no `x_seen` port; `d` is captured as-is (X propagates to `q`).

Test Plan:
- Reset: `rst_n` = 0 for 2 edges, RESET_VAL = 0 -> `q` = 0, `q_changed` = 0, `chg_cnt` = 0.
- Basic capture:
  - Setup: `clk` period 10, first rising edge t=5, `en` = 1, `wmask` = all-ones.
  - Stimulus: `d` = 1 at t=3, `d` = 0 at t=23.
  - Response: `q` = 1 after t=5; stays 1 across the t=10 falling edge and the t=15 rising edge; `q` = 0 after t=25; `chg_cnt` = 2.
- Enable/mask (WIDTH = 8, `q` = 0x00, `d` = 0xFF):
  - `en` = 0 -> `q` stays 0x00 and `q_changed` = 0.
  - `en` = 1, `wmask` = 0x0F -> `q` = 0x0F and one `q_changed` pulse.
- No-change capture: `d` = `q` with `en` = 1 -> `q_changed` = 0 and `chg_cnt` unchanged.
- Saturation:
  - Setup: CNT_W = 2.
  - Stimulus: toggle `d` every edge for 6 edges.
  - Response: `chg_cnt` reaches 3 and holds at 3.
- Mid-operation reset: `rst_n` = 0 on the same edge as `d` = 1 with `en` = 1 -> `q` = RESET_VAL, not 1, and `q_changed` = 0.
